rtc_bus_cycle_fsm: RTL and testbench

//  Bus-cycle timing engine between the RTC read/write sequencers and the RTC's

---
 rtl/rtc_bus_cycle_fsm.sv | 179 +++++++++++++++++
 tb/tb_rtc_bus_cycle_fsm.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_cycle_fsm.sv
// Bus-cycle timing engine for the RTC multiplexed address/data port.
// One accepted request runs a full address phase, a bus gap, then a data phase.
module rtc_bus_cycle_fsm #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        A_SETUP = 4'd1,
        A_PULSE = 4'd2,
        A_HOLD  = 4'd3,
        GAP     = 4'd4,
        D_SETUP = 4'd5,
        D_PULSE = 4'd6,
        D_HOLD  = 4'd7,
        DONE    = 4'd8
    } state_t;

    localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
    localparam logic [7:0] LD_PULSE = 8'(T_PULSE - 1);
    localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);
    localparam logic [7:0] LD_GAP   = 8'(T_GAP - 1);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       rw_reg;
    logic [7:0] addr_reg, wdata_reg;

    logic       accept;
    logic       cur_rw;
    logic [7:0] cur_addr, cur_wdata;

    logic [7:0] ad_out_next;
    logic       ad_oe_next, a_d_next, cs_next, rd_next, wr_next, busy_next, done_next;

    assign accept = (state_reg == IDLE) && start;

    // Outputs are decoded from the next state, so on the accepting edge the
    // request fields come straight from the inputs rather than the latches.
    assign cur_rw    = (state_reg == IDLE) ? rw    : rw_reg;
    assign cur_addr  = (state_reg == IDLE) ? addr  : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? wdata : wdata_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = A_SETUP;
                    cnt_next   = LD_SETUP;
                end
            end
            A_SETUP, A_PULSE, A_HOLD, GAP, D_SETUP, D_PULSE, D_HOLD: begin
                if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end else begin
                    unique case (state_reg)
                        A_SETUP: begin state_next = A_PULSE; cnt_next = LD_PULSE; end
                        A_PULSE: begin state_next = A_HOLD;  cnt_next = LD_HOLD;  end
                        A_HOLD:  begin state_next = GAP;     cnt_next = LD_GAP;   end
                        GAP:     begin state_next = D_SETUP; cnt_next = LD_SETUP; end
                        D_SETUP: begin state_next = D_PULSE; cnt_next = LD_PULSE; end
                        D_PULSE: begin state_next = D_HOLD;  cnt_next = LD_HOLD;  end
                        default: begin state_next = DONE;    cnt_next = 8'd0;     end
                    endcase
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ad_out_next = 8'd0;
        ad_oe_next  = 1'b0;
        a_d_next    = 1'b1;
        cs_next     = 1'b1;
        rd_next     = 1'b1;
        wr_next     = 1'b1;
        busy_next   = (state_next != IDLE);
        done_next   = 1'b0;
        unique case (state_next)
            A_SETUP, A_PULSE, A_HOLD: begin
                cs_next     = 1'b0;
                a_d_next    = 1'b0;
                ad_oe_next  = 1'b1;
                ad_out_next = cur_addr;
                wr_next     = (state_next != A_PULSE);
            end
            D_SETUP, D_PULSE, D_HOLD: begin
                cs_next = 1'b0;
                if (cur_rw) begin
                    rd_next = (state_next != D_PULSE);
                end else begin
                    ad_oe_next  = 1'b1;
                    ad_out_next = cur_wdata;
                    wr_next     = (state_next != D_PULSE);
                end
            end
            DONE:    done_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ad_out <= 8'd0;
            ad_oe  <= 1'b0;
            a_d    <= 1'b1;
            cs     <= 1'b1;
            rd     <= 1'b1;
            wr     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            ad_out <= ad_out_next;
            ad_oe  <= ad_oe_next;
            a_d    <= a_d_next;
            cs     <= cs_next;
            rd     <= rd_next;
            wr     <= wr_next;
            busy   <= busy_next;
            done   <= done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rw_reg    <= 1'b0;
            addr_reg  <= 8'd0;
            wdata_reg <= 8'd0;
        end else if (accept) begin
            rw_reg    <= rw;
            addr_reg  <= addr;
            wdata_reg <= wdata;
        end
    end

    // Read data is taken on the edge that ends the last read-strobe cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= 8'd0;
        end else if (state_reg == D_PULSE && cnt_reg == 8'd0 && rw_reg) begin
            rdata <= ad_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_cycle_fsm.sv
// Directed bench for rtc_bus_cycle_fsm: default timing instance plus an all-ones
// timing instance, checked cycle by cycle against a phase table.
module tb_rtc_bus_cycle_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       start_f = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] addr = 8'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] ad_in = 8'd0;

    logic [7:0] ad_out, rdata;
    logic       ad_oe, a_d, cs, rd, wr, busy, done;
    logic [7:0] f_ad_out, f_rdata;
    logic       f_ad_oe, f_a_d, f_cs, f_rd, f_wr, f_busy, f_done;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rtc_bus_cycle_fsm dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
        .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .rdata(rdata), .busy(busy),
        .done(done)
    );

    rtc_bus_cycle_fsm #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1)) dut_f (
        .clk(clk), .reset(reset), .start(start_f), .rw(rw), .addr(addr),
        .wdata(wdata), .ad_in(ad_in), .ad_out(f_ad_out), .ad_oe(f_ad_oe),
        .a_d(f_a_d), .cs(f_cs), .rd(f_rd), .wr(f_wr), .rdata(f_rdata),
        .busy(f_busy), .done(f_done)
    );

    // Phase code for cycle k after the accepting edge:
    // 0 idle, 1..3 address setup/pulse/hold, 4 gap, 5..7 data setup/pulse/hold, 8 done
    function automatic int exp_phase(input int k, input int s, input int p, input int h, input int g);
        int b;
        b = s;                 if (k < b) return 1;
        b += p;                if (k < b) return 2;
        b += h;                if (k < b) return 3;
        b += g;                if (k < b) return 4;
        b += s;                if (k < b) return 5;
        b += p;                if (k < b) return 6;
        b += h;                if (k < b) return 7;
        if (k == b) return 8;
        return 0;
    endfunction

    // Expected {cs, a_d, rd, wr, ad_oe, busy, done}
    function automatic logic [6:0] exp_ctl(input int ph, input logic rd_op);
        case (ph)
            1, 3:    return 7'b0011110;
            2:       return 7'b0010110;
            4:       return 7'b1111010;
            5, 7:    return rd_op ? 7'b0111010 : 7'b0111110;
            6:       return rd_op ? 7'b0101010 : 7'b0110110;
            8:       return 7'b1111011;
            default: return 7'b1111000;
        endcase
    endfunction

    function automatic logic [7:0] exp_bus(input int ph, input logic [7:0] a, input logic [7:0] d);
        if (ph >= 1 && ph <= 3) return a;
        if (ph >= 5 && ph <= 7) return d;
        return 8'd0;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({cs, a_d, rd, wr, ad_oe, busy, done} !== 7'b1111000) begin
            n_fail++;
            $display("FAIL reset_ctl got %b exp %b", {cs, a_d, rd, wr, ad_oe, busy, done}, 7'b1111000);
        end
        n_cmp++;
        if (ad_out !== 8'd0 || rdata !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data ad_out=%h rdata=%h exp 00/00", ad_out, rdata);
        end
        n_cmp++;
        if ({f_cs, f_a_d, f_rd, f_wr, f_ad_oe, f_busy, f_done} !== 7'b1111000) begin
            n_fail++;
            $display("FAIL reset_fast_ctl got %b exp %b", {f_cs, f_a_d, f_rd, f_wr, f_ad_oe, f_busy, f_done}, 7'b1111000);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        $display("reset: outputs idle after reset");
    endtask

    task automatic test_write();
        int ph;
        logic [6:0] ctl;
        start = 1'b1; rw = 1'b0; addr = 8'h21; wdata = 8'h45;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            ph = exp_phase(k, 2, 4, 2, 2);
            ctl = exp_ctl(ph, 1'b0);
            n_cmp++;
            if ({cs, a_d, rd, wr, ad_oe, busy, done} !== ctl) begin
                n_fail++;
                $display("FAIL write_ctl k=%0d got %b exp %b", k, {cs, a_d, rd, wr, ad_oe, busy, done}, ctl);
            end
            if (ctl[2]) begin
                n_cmp++;
                if (ad_out !== exp_bus(ph, 8'h21, 8'h45)) begin
                    n_fail++;
                    $display("FAIL write_bus k=%0d got %h exp %h", k, ad_out, exp_bus(ph, 8'h21, 8'h45));
                end
            end
        end
        $display("write: addr=21 wdata=45 done expected at cycle 18");
    endtask

    task automatic test_read();
        int ph;
        logic [6:0] ctl;
        start = 1'b1; rw = 1'b1; addr = 8'h22; wdata = 8'hFF; ad_in = 8'hAA;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            ph = exp_phase(k, 2, 4, 2, 2);
            ctl = exp_ctl(ph, 1'b1);
            n_cmp++;
            if ({cs, a_d, rd, wr, ad_oe, busy, done} !== ctl) begin
                n_fail++;
                $display("FAIL read_ctl k=%0d got %b exp %b", k, {cs, a_d, rd, wr, ad_oe, busy, done}, ctl);
            end
            if (ctl[2]) begin
                n_cmp++;
                if (ad_out !== 8'h22) begin
                    n_fail++;
                    $display("FAIL read_bus k=%0d got %h exp 22", k, ad_out);
                end
            end
            if (k == 15) begin
                n_cmp++;
                if (rdata !== 8'h00) begin
                    n_fail++;
                    $display("FAIL read_early k=%0d got %h exp 00", k, rdata);
                end
            end
            if (k == 16 || k == 18) begin
                n_cmp++;
                if (rdata !== 8'h37) begin
                    n_fail++;
                    $display("FAIL read_rdata k=%0d got %h exp 37", k, rdata);
                end
            end
            // Valid read data only while the read strobe is low
            ad_in = (k >= 12 && k <= 14) || k == 15 ? 8'h37 : 8'hAA;
            if (k == 11) ad_in = 8'h37;
        end
        ad_in = 8'h00;
        $display("read: addr=22 rdata=%h", rdata);
    endtask

    task automatic test_drop_start();
        int ph;
        int n_done;
        logic [6:0] ctl;
        n_done = 0;
        start = 1'b1; rw = 1'b0; addr = 8'h3C; wdata = 8'h81;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            start = (k >= 5 && k <= 8);
            if (k == 5) begin
                rw = 1'b1; addr = 8'h99; wdata = 8'h66;
            end
            n_done += int'(done);
            ph = exp_phase(k, 2, 4, 2, 2);
            ctl = exp_ctl(ph, 1'b0);
            n_cmp++;
            if ({cs, a_d, rd, wr, ad_oe, busy, done} !== ctl) begin
                n_fail++;
                $display("FAIL drop_ctl k=%0d got %b exp %b", k, {cs, a_d, rd, wr, ad_oe, busy, done}, ctl);
            end
            if (ctl[2]) begin
                n_cmp++;
                if (ad_out !== exp_bus(ph, 8'h3C, 8'h81)) begin
                    n_fail++;
                    $display("FAIL drop_bus k=%0d got %h exp %h", k, ad_out, exp_bus(ph, 8'h3C, 8'h81));
                end
            end
        end
        n_cmp++;
        if (n_done !== 1) begin
            n_fail++;
            $display("FAIL drop_done_count got %0d exp 1", n_done);
        end
        n_cmp++;
        if (rdata !== 8'h37) begin
            n_fail++;
            $display("FAIL drop_rdata_hold got %h exp 37", rdata);
        end
        $display("drop_start: done pulses=%0d", n_done);
    endtask

    task automatic test_back_to_back();
        int ph;
        logic [6:0] ctl;
        start = 1'b1; rw = 1'b0; addr = 8'h10; wdata = 8'h20;
        for (int k = 0; k < 42; k++) begin
            @(posedge clk); #1;
            ph = exp_phase(k % 20, 2, 4, 2, 2);
            ctl = exp_ctl(ph, 1'b0);
            n_cmp++;
            if ({cs, a_d, rd, wr, ad_oe, busy, done} !== ctl) begin
                n_fail++;
                $display("FAIL b2b_ctl k=%0d got %b exp %b", k, {cs, a_d, rd, wr, ad_oe, busy, done}, ctl);
            end
            n_cmp++;
            if (!rd && !wr) begin
                n_fail++;
                $display("FAIL b2b_overlap k=%0d rd=%b wr=%b exp not both 0", k, rd, wr);
            end
            n_cmp++;
            if (cs && (!rd || !wr)) begin
                n_fail++;
                $display("FAIL b2b_strobe_cs k=%0d cs=%b rd=%b wr=%b", k, cs, rd, wr);
            end
        end
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("back_to_back: two accesses 20 cycles apart");
    endtask

    task automatic test_reset_mid();
        int ph;
        logic [6:0] ctl;
        start = 1'b1; rw = 1'b0; addr = 8'h21; wdata = 8'h45;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        n_cmp++;
        if (wr !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_in_pulse got wr=%b exp 0", wr);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({cs, a_d, rd, wr, ad_oe, busy, done} !== 7'b1111000) begin
            n_fail++;
            $display("FAIL rmid_ctl got %b exp %b", {cs, a_d, rd, wr, ad_oe, busy, done}, 7'b1111000);
        end
        n_cmp++;
        if (rdata !== 8'h00 || ad_out !== 8'h00) begin
            n_fail++;
            $display("FAIL rmid_data rdata=%h ad_out=%h exp 00/00", rdata, ad_out);
        end
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({cs, a_d, rd, wr, ad_oe, busy, done} !== 7'b1111000) begin
                n_fail++;
                $display("FAIL rmid_idle k=%0d got %b exp 1111000", k, {cs, a_d, rd, wr, ad_oe, busy, done});
            end
        end
        start = 1'b1; rw = 1'b0; addr = 8'h5A; wdata = 8'hC3;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            ph = exp_phase(k, 2, 4, 2, 2);
            ctl = exp_ctl(ph, 1'b0);
            n_cmp++;
            if ({cs, a_d, rd, wr, ad_oe, busy, done} !== ctl) begin
                n_fail++;
                $display("FAIL rmid_after_ctl k=%0d got %b exp %b", k, {cs, a_d, rd, wr, ad_oe, busy, done}, ctl);
            end
            if (ctl[2]) begin
                n_cmp++;
                if (ad_out !== exp_bus(ph, 8'h5A, 8'hC3)) begin
                    n_fail++;
                    $display("FAIL rmid_after_bus k=%0d got %h exp %h", k, ad_out, exp_bus(ph, 8'h5A, 8'hC3));
                end
            end
        end
        $display("reset_mid: reset in address pulse, then full write");
    endtask

    task automatic test_fast_timing();
        int ph;
        logic [6:0] ctl;
        start_f = 1'b1; rw = 1'b0; addr = 8'h77; wdata = 8'h88;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            start_f = 1'b0;
            ph = exp_phase(k, 1, 1, 1, 1);
            ctl = exp_ctl(ph, 1'b0);
            n_cmp++;
            if ({f_cs, f_a_d, f_rd, f_wr, f_ad_oe, f_busy, f_done} !== ctl) begin
                n_fail++;
                $display("FAIL fast_ctl k=%0d got %b exp %b", k, {f_cs, f_a_d, f_rd, f_wr, f_ad_oe, f_busy, f_done}, ctl);
            end
            if (ctl[2]) begin
                n_cmp++;
                if (f_ad_out !== exp_bus(ph, 8'h77, 8'h88)) begin
                    n_fail++;
                    $display("FAIL fast_bus k=%0d got %h exp %h", k, f_ad_out, exp_bus(ph, 8'h77, 8'h88));
                end
            end
        end
        $display("fast_timing: all-ones timing, done expected at cycle 7");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_drop_start();
        test_back_to_back();
        test_reset_mid();
        test_fast_timing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
